// File: rtl/aidc_lite_block_pack.sv
// AIDC-Lite block packer: collects compressed words into a 512-bit line and emits it, or the raw line on failure.
// Optional AIDC_LITE_MIN_GAIN_EN: full-length (8-word) successful blocks are emitted raw.
module aidc_lite_block_pack (
    input  logic         clk,
    input  logic         rst,
    input  logic         raw_valid_i,
    output logic         raw_ready_o,
    input  logic [511:0] raw_data_i,
    input  logic         wr_valid_i,
    input  logic [2:0]   wr_addr_i,
    input  logic [63:0]  wr_data_i,
    input  logic         done_i,
    input  logic         fail_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [511:0] data_o,
    output logic         comp_o,
    output logic [3:0]   len_o,
    output logic         err_o
);

    typedef enum logic [1:0] {IDLE, COLLECT, OUT} state_t;

    state_t       state_q, state_d;
    logic [511:0] raw_q, raw_d;
    logic [511:0] line_q, line_d;
    logic [511:0] data_q, data_d;
    logic         comp_q, comp_d;
    logic [3:0]   len_q, len_d;
    logic [3:0]   max_q, max_d;
    logic [7:0]   mask_q, mask_d;
    logic         done_q;
    logic         err_q, err_d;

    logic         rise;
    logic         wr_hit;
    logic [511:0] line_w;
    logic [3:0]   len_w;
    logic [3:0]   addr_len;
    logic         use_comp;

    always_comb begin
        state_d  = state_q;
        raw_d    = raw_q;
        line_d   = line_q;
        data_d   = data_q;
        comp_d   = comp_q;
        len_d    = len_q;
        max_d    = max_q;
        mask_d   = mask_q;
        err_d    = err_q;
        rise     = done_i & ~done_q;
        wr_hit   = wr_valid_i & (state_q == COLLECT);
        addr_len = {1'b0, wr_addr_i} + 4'd1;

        // A write landing in the completion cycle must be part of the packed line
        line_w = line_q;
        for (int i = 0; i < 8; i++) begin
            if (wr_hit && (wr_addr_i == i[2:0])) begin
                line_w[511-64*i -: 64] = wr_data_i;
            end
        end
        len_w = max_q;
        if (wr_hit && (addr_len > max_q)) begin
            len_w = addr_len;
        end

`ifdef AIDC_LITE_MIN_GAIN_EN
        use_comp = ~fail_i & (len_w != 4'd0) & (len_w != 4'd8);
`else
        use_comp = ~fail_i & (len_w != 4'd0);
`endif

        if (wr_valid_i && (state_q != COLLECT)) begin
            err_d = 1'b1;
        end
        if (rise && (state_q != COLLECT)) begin
            err_d = 1'b1;
        end
        if (wr_hit && mask_q[wr_addr_i]) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (raw_valid_i) begin
                    raw_d   = raw_data_i;
                    line_d  = '0;
                    max_d   = 4'd0;
                    mask_d  = 8'd0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                line_d = line_w;
                max_d  = len_w;
                if (wr_hit) begin
                    mask_d = mask_q | (8'd1 << wr_addr_i);
                end
                if (rise) begin
                    state_d = OUT;
                    if (use_comp) begin
                        data_d = line_w;
                        comp_d = 1'b1;
                        len_d  = len_w;
                    end else begin
                        data_d = raw_q;
                        comp_d = 1'b0;
                        len_d  = 4'd8;
                    end
                end
            end
            OUT: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            raw_q   <= '0;
            line_q  <= '0;
            data_q  <= '0;
            comp_q  <= 1'b0;
            len_q   <= 4'd0;
            max_q   <= 4'd0;
            mask_q  <= 8'd0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            raw_q   <= raw_d;
            line_q  <= line_d;
            data_q  <= data_d;
            comp_q  <= comp_d;
            len_q   <= len_d;
            max_q   <= max_d;
            mask_q  <= mask_d;
            done_q  <= done_i;
            err_q   <= err_d;
        end
    end

    assign raw_ready_o = (state_q == IDLE);
    assign valid_o     = (state_q == OUT);
    assign data_o      = data_q;
    assign comp_o      = comp_q;
    assign len_o       = len_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_aidc_lite_block_pack.sv
// Scoreboard bench for aidc_lite_block_pack: directed blocks, stall, error and reset cases.
module tb_aidc_lite_block_pack;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         raw_valid_i = 1'b0;
    logic         raw_ready_o;
    logic [511:0] raw_data_i = '0;
    logic         wr_valid_i = 1'b0;
    logic [2:0]   wr_addr_i = 3'd0;
    logic [63:0]  wr_data_i = 64'd0;
    logic         done_i = 1'b0;
    logic         fail_i = 1'b0;
    logic         valid_o;
    logic         ready_i = 1'b1;
    logic [511:0] data_o;
    logic         comp_o;
    logic [3:0]   len_o;
    logic         err_o;

    aidc_lite_block_pack dut (
        .clk(clk), .rst(rst),
        .raw_valid_i(raw_valid_i), .raw_ready_o(raw_ready_o), .raw_data_i(raw_data_i),
        .wr_valid_i(wr_valid_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .done_i(done_i), .fail_i(fail_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .comp_o(comp_o), .len_o(len_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         comp;
        logic [3:0]   len;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [63:0] W0 = 64'h0000_1111_2222_3333;
    localparam logic [63:0] W1 = 64'h1010_1010_1010_1010;
    localparam logic [63:0] W2 = 64'h2222_0000_2222_0000;
    localparam logic [63:0] W3 = 64'h3333_3333_4444_4444;
    localparam logic [63:0] W4 = 64'h4040_4040_0404_0404;
    localparam logic [63:0] W5 = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] W6 = 64'h6666_7777_8888_9999;
    localparam logic [63:0] W7 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [511:0] R1 = {8{64'hA5A5_0000_1234_5678}};
    localparam logic [511:0] R2 = {8{64'h0F0F_F0F0_0000_FFFF}};
    localparam logic [511:0] R3 = {8{64'h1357_9BDF_2468_ACE0}};

    logic [2:0]  wa[8];
    logic [63:0] wd[8];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every accepted output line
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 512'd1, 512'd0);
                end else begin
                    e = sb.pop_front();
                    chk("data_o", data_o, e.data);
                    chk("comp_o", {511'd0, comp_o}, {511'd0, e.comp});
                    chk("len_o", {508'd0, len_o}, {508'd0, e.len});
                end
            end
        end
    end

    // Called #1 after a posedge while the DUT is idle
    task automatic run_block(input logic [511:0] raw, input int n, input logic fail,
                             input bit wr_on_done, input logic [511:0] ed,
                             input logic ec, input logic [3:0] el);
        exp_t e;
        int   k;
        int   nw;
        e.data = ed;
        e.comp = ec;
        e.len  = el;
        sb.push_back(e);
        raw_valid_i = 1'b1;
        raw_data_i  = raw;
        done_i      = 1'b0;
        fail_i      = 1'b0;
        @(posedge clk); #1;
        raw_valid_i = 1'b0;
        nw = wr_on_done ? n - 1 : n;
        for (int i = 0; i < nw; i++) begin
            wr_valid_i = 1'b1;
            wr_addr_i  = wa[i];
            wr_data_i  = wd[i];
            @(posedge clk); #1;
            wr_valid_i = 1'b0;
        end
        done_i = 1'b1;
        fail_i = fail;
        if (wr_on_done) begin
            wr_valid_i = 1'b1;
            wr_addr_i  = wa[n-1];
            wr_data_i  = wd[n-1];
        end
        @(posedge clk); #1;
        wr_valid_i = 1'b0;
        k = 0;
        while (!valid_o && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        if (!valid_o) begin
            chk("valid_timeout", 512'd0, 512'd1);
        end
        if (ready_i) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int k;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_valid", {511'd0, valid_o}, 512'd0);
        chk("rst_data", data_o, 512'd0);
        chk("rst_comp", {511'd0, comp_o}, 512'd0);
        chk("rst_len", {508'd0, len_o}, 512'd0);
        chk("rst_err", {511'd0, err_o}, 512'd0);
        chk("rst_rdy", {511'd0, raw_ready_o}, 512'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        wa[0] = 3'd0; wa[1] = 3'd1; wa[2] = 3'd2;
        wd[0] = W0;   wd[1] = W1;   wd[2] = W2;
        run_block(R1, 3, 1'b0, 1'b0, {W0, W1, W2, 320'h0}, 1'b1, 4'd3);
        run_block(R2, 3, 1'b1, 1'b0, R2, 1'b0, 4'd8);
        run_block(R3, 0, 1'b0, 1'b0, R3, 1'b0, 4'd8);

        for (int i = 0; i < 8; i++) wa[i] = 3'(i);
        wd[0] = W0; wd[1] = W1; wd[2] = W2; wd[3] = W3;
        wd[4] = W4; wd[5] = W5; wd[6] = W6; wd[7] = W7;
`ifdef AIDC_LITE_MIN_GAIN_EN
        run_block(R1, 8, 1'b0, 1'b0, R1, 1'b0, 4'd8);
`else
        run_block(R1, 8, 1'b0, 1'b0, {W0, W1, W2, W3, W4, W5, W6, W7}, 1'b1, 4'd8);
`endif

        wa[0] = 3'd0; wa[1] = 3'd2;
        wd[0] = W0;   wd[1] = W2;
        run_block(R2, 2, 1'b0, 1'b0, {W0, 64'h0, W2, 320'h0}, 1'b1, 4'd3);

        wa[0] = 3'd5; wa[1] = 3'd1; wa[2] = 3'd3;
        wd[0] = W5;   wd[1] = W1;   wd[2] = W3;
        run_block(R3, 3, 1'b0, 1'b1,
                  {64'h0, W1, 64'h0, W3, 64'h0, W5, 128'h0}, 1'b1, 4'd6);

        ready_i = 1'b0;
        wa[0] = 3'd6; wd[0] = W6;
        run_block(R1, 1, 1'b0, 1'b0, {384'h0, W6, 64'h0}, 1'b1, 4'd7);
        for (int c = 0; c < 6; c++) begin
            chk("stall_valid", {511'd0, valid_o}, 512'd1);
            chk("stall_data", data_o, {384'h0, W6, 64'h0});
            chk("stall_len", {508'd0, len_o}, 512'd7);
            chk("stall_rdy", {511'd0, raw_ready_o}, 512'd0);
            if (c < 5) begin
                @(posedge clk); #1;
            end
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_valid", {511'd0, valid_o}, 512'd0);
        chk("post_hs_rdy", {511'd0, raw_ready_o}, 512'd1);
        chk("clean_err", {511'd0, err_o}, 512'd0);

        wr_valid_i = 1'b1;
        wr_addr_i  = 3'd4;
        wr_data_i  = W4;
        @(posedge clk); #1;
        wr_valid_i = 1'b0;
        chk("idle_wr_err", {511'd0, err_o}, 512'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_sticky", {511'd0, err_o}, 512'd1);
        chk("idle_wr_nostate", {511'd0, raw_ready_o}, 512'd1);

        raw_valid_i = 1'b1;
        raw_data_i  = R2;
        done_i      = 1'b0;
        @(posedge clk); #1;
        raw_valid_i = 1'b0;
        wr_valid_i  = 1'b1;
        wr_addr_i   = 3'd0;
        wr_data_i   = W0;
        @(posedge clk); #1;
        wr_valid_i = 1'b0;
        chk("mid_rdy_low", {511'd0, raw_ready_o}, 512'd0);
        rst = 1'b1;
        #1;
        chk("arst_valid", {511'd0, valid_o}, 512'd0);
        chk("arst_err", {511'd0, err_o}, 512'd0);
        chk("arst_rdy", {511'd0, raw_ready_o}, 512'd1);
        chk("arst_data", data_o, 512'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        wa[0] = 3'd1; wa[1] = 3'd1;
        wd[0] = W1;   wd[1] = W4;
        run_block(R3, 2, 1'b0, 1'b0, {64'h0, W4, 384'h0}, 1'b1, 4'd2);
        chk("dup_wr_err", {511'd0, err_o}, 512'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 512'(sb.size()), 512'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aidc_lite_block_pack.md
# aidc_lite_block_pack

Downstream stage of the AIDC-Lite code concatenator. Collects the concatenator's 64-bit word writes (addr 0..7) into a 512-bit compressed line, detects block completion from the done/fail pair, and emits either the compressed line or the original raw line on a valid/ready output toward the memory-side writer. It holds the raw line for the whole block so that a failed compression falls back to uncompressed storage.

## Interface
- No parameters; line = 512 bits, word = 64 bits, 8 words per line (fixed).
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- raw_valid_i  in  1  raw line offered for the next block
- raw_ready_o  out  1  raw line accepted (high only in IDLE)
- raw_data_i  in  512  uncompressed line
- wr_valid_i  in  1  concatenator word write (no backpressure)
- wr_addr_i  in  3  word index 0..7
- wr_data_i  in  64  compressed word
- done_i  in  1  concatenator done (level, sticky until next sop)
- fail_i  in  1  concatenator fail, qualified by done_i rising
- valid_o  out  1  output line valid
- ready_i  in  1  downstream accepts line
- data_o  out  512  output line
- comp_o  out  1  1 = data_o is compressed, 0 = raw
- len_o  out  4  used words 1..8 (8 when raw)
- err_o  out  1  sticky protocol error

## Operation
- FSM states IDLE, COLLECT, OUT. Reset -> IDLE.
- IDLE: raw_ready_o=1. raw_valid_i=1 -> latch raw_data_i, clear compressed line buffer to 0, clear max-address tracker, -> COLLECT.
- COLLECT: wr_valid_i writes wr_data_i to line bits [511-64*a -: 64], a = wr_addr_i (word 0 at MSB, prefix-first). Tracker len = max(a)+1 over accepted writes.
- Completion: done_i & ~done_q (done_q = done_i registered, reset value 1). Write in the same cycle as completion is applied before packing.
- On completion: fail_i=1 or no word written -> data_o=raw line, comp_o=0, len_o=8; else data_o=compressed line, comp_o=1, len_o=len. -> OUT.
- OUT: valid_o=1, outputs stable until valid_o & ready_i; then -> IDLE.
- Protocol errors (set err_o, cleared only by rst): wr_valid_i or done_i rising outside COLLECT (write dropped, no state change); repeated write to same address within one block (later write wins).
- Gaps in address (e.g. 0,2) leave the missing word zero; len still max+1.

## Timing
- Reset values: valid_o=0, data_o=0, comp_o=0, len_o=0, err_o=0, raw_ready_o=1.
- Raw accept at cycle T -> COLLECT at T+1; writes accepted from T+1.
- Done rising at cycle T -> valid_o=1 at T+1 with final data_o/comp_o/len_o registered.
- ready_i high when valid_o rises -> handshake same cycle, IDLE at next cycle, raw_ready_o=1 then; min block turnaround 3 cycles after last write.
- ready_i low -> valid_o held indefinitely; input writes during OUT set err_o.
- Reset asserted mid-block: immediate (asynchronous) return to IDLE, all buffers and outputs to reset values; in-flight block discarded.

## Configuration
- AIDC_LITE_MIN_GAIN_EN defined: a successful block with len=8 (no saving) is emitted as raw (comp_o=0, data_o=raw line, len_o=8).
- Undefined: len=8 successful block is emitted compressed (comp_o=1, len_o=8).

## Test plan
- Raw line R, writes addr 0..2 words W0..W2, done rises with fail=0 -> one cycle later valid_o=1, comp_o=1, len_o=3, data_o={W0,W1,W2,320'h0}.
- Same block with fail=1 on done rise -> data_o=R, comp_o=0, len_o=8.
- Done rise with no prior writes (concatenator overflow fail) -> raw output, len_o=8.
- 8 writes, fail=0: macro defined -> comp_o=0, data_o=R; undefined -> comp_o=1, len_o=8.
- ready_i held low 5 cycles after valid_o -> outputs stable 6 cycles; raw_ready_o=0 until handshake, then 1 next cycle.
- Write while in IDLE -> err_o=1 and stays 1; rst pulse mid-COLLECT -> valid_o=0, err_o=0, raw_ready_o=1 immediately.
